// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter datapath and its output buffer.
//   DATA_W          sample width (two's complement, filter dout format)
//   IIR_FIFO_DEPTH  entries in the output buffer FIFO
//   IIR_FRAC_BITS   fractional bits of the filter's Q-format samples
//   sample_t        one filtered sample
package iir_pkg;

    localparam int DATA_W         = 9;
    localparam int IIR_FIFO_DEPTH = 8;
    localparam int IIR_FRAC_BITS  = 7;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/iir_fifo_ram.sv
// Storage array for the output buffer FIFO: DEPTH x DATA_W registers,
// one synchronous write port and one asynchronous (show-ahead) read port.
// Storage is deliberately not reset; validity is tracked by the owner.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data (combinational from the array)
module iir_fifo_ram #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: store one sample per enabled edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iir_out_buffer.sv
// Output buffer behind iir_filter: captures every filtered sample into a
// small FIFO and hands it to a consumer over a valid/ready handshake with
// first-word-fall-through. The filter cannot be stalled, so a sample that
// arrives while the FIFO is full and nothing is leaving is dropped and the
// sticky ovf flag is raised.
// Ports:
//   clock    system clock, rising edge
//   rst_n    asynchronous active-low reset
//   vin/din  sample valid / sample from the filter
//   rdy_in   consumer ready
//   clr_ovf  synchronous clear of ovf (a coincident drop wins)
//   dout     head-of-FIFO sample, 0 while empty
//   vout     dout valid (FIFO not empty)
//   full     count == DEPTH
//   empty    count == 0
//   count    entries held, 0..DEPTH
//   ovf      sticky sample-dropped flag
module iir_out_buffer #(
    parameter int DATA_W = iir_pkg::DATA_W,
    parameter int DEPTH  = iir_pkg::IIR_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              vin,
    input  logic [DATA_W-1:0] din,
    input  logic              rdy_in,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] dout,
    output logic              vout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic              rd_s;
    logic              wr_s;
    logic              drop_s;
    logic [DATA_W-1:0] rdata_s;

    // Handshake decode: a pop frees a slot, so a full FIFO still accepts
    // a sample on the same edge it is read.
    always_comb begin
        rd_s   = ~empty_q & rdy_in;
        wr_s   = vin & (~full_q | rd_s);
        drop_s = vin & full_q & ~rd_s;
    end

    // Next-state for pointers, occupancy, flags and overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, rd_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear must leave the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // Flags come from occupancy; pointers alone are ambiguous when equal.
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == {(ADDR_W+1){1'b0}});
    end

    // State registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    iir_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (wr_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata_s)
    );

    // Stale array contents must never show while the FIFO is empty.
    assign dout  = empty_q ? {DATA_W{1'b0}} : rdata_s;
    assign vout  = ~empty_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_iir_out_buffer.sv
// Scoreboard bench for iir_out_buffer: the driver keeps a behavioural FIFO
// model (occupancy, sticky flag, queue of accepted samples); the monitor
// compares flags every cycle and pops the expected sample on each DUT pop.
module tb_iir_out_buffer;
    import iir_pkg::*;

    localparam int DEPTH = IIR_FIFO_DEPTH;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        vin;
    sample_t     din;
    logic        rdy_in;
    logic        clr_ovf;
    sample_t     dout;
    logic        vout;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        ovf;

    int          n_vec = 0;
    int          n_err = 0;
    sample_t     exp_q[$];
    int          m_cnt = 0;
    logic        m_ovf = 1'b0;
    logic        mon_en = 1'b0;

    iir_out_buffer dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .vin     (vin),
        .din     (din),
        .rdy_in  (rdy_in),
        .clr_ovf (clr_ovf),
        .dout    (dout),
        .vout    (vout),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: flags every cycle, data on each handshake.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("count", int'(count), m_cnt);
            chk("empty", int'(empty), int'(m_cnt == 0));
            chk("full",  int'(full),  int'(m_cnt == DEPTH));
            chk("vout",  int'(vout),  int'(m_cnt != 0));
            chk("ovf",   int'(ovf),   int'(m_ovf));
            if (!vout) chk("dout_idle", int'(dout), 0);
            if (vout && rdy_in) begin
                if (exp_q.size() == 0) chk("underrun", 1, 0);
                else                   chk("dout", int'(dout), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; the model is advanced with the pre-edge state.
    task automatic cyc(input logic v, input sample_t d, input logic r, input logic c);
        logic rd, wr, drop;
        vin = v; din = d; rdy_in = r; clr_ovf = c;
        @(posedge clock);
        if (rst_n) begin
            rd   = (m_cnt > 0) && r;
            wr   = v && ((m_cnt < DEPTH) || rd);
            drop = v && !wr;
            if (wr) exp_q.push_back(d);
            m_cnt = m_cnt + int'(wr) - int'(rd);
            if (drop)   m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
        end
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (m_cnt > 0 && k < 40) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            k++;
        end
        chk("drain_timeout", m_cnt, 0);
        @(negedge clock);
        #1;
        chk("leftover", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr;
        // 1: reset held with a live input
        rst_n = 1'b0; vin = 1'b1; din = 9'h055; rdy_in = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_vout",  int'(vout),  0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf",   int'(ovf),   0);
        chk("rst_dout",  int'(dout),  0);
        chk("rst_full",  int'(full),  0);
        vin = 1'b0;
        rst_n = 1'b1;
        #1 mon_en = 1'b1;

        // 2: pass-through
        cyc(1'b1, 9'h1A3, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // 3: fill with 1..9, the ninth is dropped
        for (int i = 1; i <= 9; i++) cyc(1'b1, sample_t'(i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        // 4: full with simultaneous push and pop
        cyc(1'b1, 9'h100, 1'b1, 1'b0);
        drain();

        // 5: wrap with alternating ready, ovf cleared first
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, sample_t'(i), 1'b1, 1'b0);
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        drain();

        // Random traffic at several consumer duty cycles
        for (int p = 0; p < 3; p++) begin
            pr = (p == 0) ? 20 : ((p == 1) ? 50 : 90);
            for (int i = 0; i < 120; i++) begin
                cyc(1'b1 && ($urandom % 4 != 0), sample_t'($urandom_range(0, 511)),
                    ($urandom % 100) < pr, ($urandom % 16) == 0);
            end
        end
        drain();

        // 6: async reset between edges with five entries held
        for (int i = 0; i < 5; i++) cyc(1'b1, sample_t'(9'h0A0 + i), 1'b0, 1'b0);
        @(negedge clock);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_vout",  int'(vout),  0);
        chk("async_empty", int'(empty), 1);
        chk("async_dout",  int'(dout),  0);
        exp_q.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
        vin = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        #1 mon_en = 1'b1;

        // clr_ovf coinciding with a drop keeps ovf set; a lone clear resets it
        for (int i = 0; i < 9; i++) cyc(1'b1, sample_t'(9'h1F0 + i), 1'b0, 1'b0);
        cyc(1'b1, 9'h1FF, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
